// File: rtl/parking_pkg.sv
// Shared definitions for the parking slot manager.
// Holds the entry FSM state type and the helper that decides which spots
// a given request may be granted.
package parking_pkg;

   // Entry sequence: wait for a car, grant one spot, hold the barrier up
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      GATE  = 2'd2
   } entry_state_t;

   localparam int MAX_SPOTS = 64;

   // Bit i set when spot i may be handed to this request. With the reserve
   // feature on, the top rsv_spots indices are withheld from non-permit cars.
   function automatic logic [MAX_SPOTS-1:0] eligible_mask(input int   num_spots,
                                                          input int   rsv_spots,
                                                          input logic reserve_en,
                                                          input logic permit);
      logic [MAX_SPOTS-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_SPOTS; i++) begin
         if (i < num_spots) begin
            if (!reserve_en || permit || (i < num_spots - rsv_spots)) begin
               mask[i] = 1'b1;
            end
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/park_lowest_free.sv
// Combinational priority encoder: finds the lowest spot that is both free
// in the occupancy map and allowed by the eligibility mask.
module park_lowest_free
   import parking_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     map,
   input  logic [N-1:0]     mask,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   // Scan from the top down so the lowest candidate is the last one written
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!map[i] && mask[i]) begin
            found = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking lot controller: grants the lowest eligible free spot to an entering
// car, holds the entry barrier up for a fixed time, and frees spots on exit.
// The occupancy map is the single source of truth; counts derive from it.
// Optional feature macro: PARK_RESERVE_EN (top RSV_SPOTS spots are permit-only).
module parking_slot_manager
   import parking_pkg::*;
#(
   parameter int NUM_SPOTS   = 8,
   parameter int IDX_W       = $clog2(NUM_SPOTS),
   parameter int CNT_W       = $clog2(NUM_SPOTS + 1),
   parameter int GATE_CYCLES = 16,
   parameter int RSV_SPOTS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enter_req,
   input  logic                 permit,
   output logic                 enter_ack,
   output logic                 enter_nack,
   output logic [IDX_W-1:0]     enter_spot,
   output logic                 gate_open,
   input  logic                 exit_req,
   input  logic [IDX_W-1:0]     exit_spot,
   output logic                 exit_ack,
   output logic                 exit_err,
   output logic [NUM_SPOTS-1:0] occupied_map,
   output logic [CNT_W-1:0]     occupancy,
   output logic [CNT_W-1:0]     available,
   output logic                 parking_full
);

`ifdef PARK_RESERVE_EN
   localparam logic RESERVE_EN = 1'b1;
`else
   localparam logic RESERVE_EN = 1'b0;
`endif

   localparam int GCW = $clog2(GATE_CYCLES + 1);

   entry_state_t         state, state_next;
   logic                 permit_q, permit_next;
   logic [GCW-1:0]       gate_cnt, cnt_next;
   logic [MAX_SPOTS-1:0] elig_all;
   logic [NUM_SPOTS-1:0] elig;
   logic                 free_found;
   logic [IDX_W-1:0]     free_idx;
   logic [NUM_SPOTS-1:0] map_next;
   logic                 gate_next, ack_next, nack_next, exit_ack_next, exit_err_next;
   logic [IDX_W-1:0]     spot_next;
   logic                 exit_hit;
   logic [CNT_W-1:0]     occ_next;

   // Eligibility follows the live permit while idle and the latched one during allocation
   always_comb begin
      elig_all = eligible_mask(NUM_SPOTS, RSV_SPOTS, RESERVE_EN,
                               (state == ALLOC) ? permit_q : permit);
      elig     = elig_all[NUM_SPOTS-1:0];
   end

   park_lowest_free #(
      .N     (NUM_SPOTS),
      .IDX_W (IDX_W)
   ) u_lowest_free (
      .map   (occupied_map),
      .mask  (elig),
      .found (free_found),
      .index (free_idx)
   );

   // Next-state logic: exits apply in every state, entry follows the FSM
   always_comb begin
      state_next    = state;
      permit_next   = permit_q;
      cnt_next      = gate_cnt;
      map_next      = occupied_map;
      gate_next     = gate_open;
      ack_next      = 1'b0;
      nack_next     = 1'b0;
      spot_next     = enter_spot;
      exit_ack_next = 1'b0;
      exit_err_next = 1'b0;
      exit_hit      = 1'b0;

      if (exit_req) begin
         for (int i = 0; i < NUM_SPOTS; i++) begin
            if (exit_spot == IDX_W'(i)) begin
               exit_hit = occupied_map[i];
               map_next[i] = 1'b0;
            end
         end
         exit_ack_next = exit_hit;
         exit_err_next = !exit_hit;
      end

      case (state)
         IDLE: begin
            if (enter_req) begin
               if (free_found) begin
                  state_next  = ALLOC;
                  permit_next = permit;
               end else begin
                  nack_next = 1'b1;
               end
            end
         end
         ALLOC: begin
            if (free_found) begin
               map_next[free_idx] = 1'b1;
               ack_next   = 1'b1;
               spot_next  = free_idx;
               gate_next  = 1'b1;
               cnt_next   = GCW'(GATE_CYCLES - 1);
               state_next = GATE;
            end else begin
               state_next = IDLE;
            end
         end
         GATE: begin
            if (gate_cnt == '0) begin
               gate_next  = 1'b0;
               state_next = IDLE;
            end else begin
               cnt_next = gate_cnt - 1'b1;
            end
         end
         default: begin
            gate_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // Occupancy is the popcount of the map that will be stored this edge
   always_comb begin
      occ_next = '0;
      for (int i = 0; i < NUM_SPOTS; i++) begin
         occ_next = occ_next + CNT_W'(map_next[i]);
      end
   end

   // Register the FSM, the map and every output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         permit_q     <= 1'b0;
         gate_cnt     <= '0;
         occupied_map <= '0;
         gate_open    <= 1'b0;
         enter_ack    <= 1'b0;
         enter_nack   <= 1'b0;
         enter_spot   <= '0;
         exit_ack     <= 1'b0;
         exit_err     <= 1'b0;
         occupancy    <= '0;
         available    <= CNT_W'(NUM_SPOTS);
         parking_full <= 1'b0;
      end else begin
         state        <= state_next;
         permit_q     <= permit_next;
         gate_cnt     <= cnt_next;
         occupied_map <= map_next;
         gate_open    <= gate_next;
         enter_ack    <= ack_next;
         enter_nack   <= nack_next;
         enter_spot   <= spot_next;
         exit_ack     <= exit_ack_next;
         exit_err     <= exit_err_next;
         occupancy    <= occ_next;
         available    <= CNT_W'(NUM_SPOTS) - occ_next;
         parking_full <= (occ_next == CNT_W'(NUM_SPOTS));
      end
   end

endmodule
